// File: rtl/fo_interp_upsampler.sv
// Linear-interpolating upsampler feeding the first-order sigma-delta DAC.
// Buffers slow-rate samples in a small FIFO and ramps between them over 2^RATE_LOG2 clocks.
module fo_interp_upsampler #(
  parameter int BITS      = 16,
  parameter int RATE_LOG2 = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BITS-1:0]      out,
  output logic                 underrun,
  output logic [FIFO_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int ACC_W = BITS + RATE_LOG2 + 1;
  localparam logic [FIFO_LOG2:0] DEPTH_L = (FIFO_LOG2 + 1)'(DEPTH);

  logic [RATE_LOG2-1:0] phase;
  logic [BITS-1:0]      mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   level;
  logic [BITS-1:0]      prev;
  logic [BITS-1:0]      cur;
  logic [BITS:0]        delta;
  logic [ACC_W-1:0]     acc;

  logic full;
  logic empty;
  logic boundary;
  logic push;
  logic pop;

  // Handshake: a sample transfers on any edge where in_valid && in_ready;
  // in_data need only be stable for that edge, and in_ready never depends on in_valid.
  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign boundary = &phase;
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;
  assign pop      = boundary && !empty;

  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      prev     <= '0;
      cur      <= '0;
      delta    <= '0;
      acc      <= '0;
      out      <= '0;
      underrun <= 1'b0;
    end else begin
      phase <= phase + RATE_LOG2'(1);
      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      level <= level + (FIFO_LOG2 + 1)'(push) - (FIFO_LOG2 + 1)'(pop);

      // At a boundary the accumulator is re-seeded from cur so rounding never drifts.
      if (boundary) begin
        prev <= cur;
        acc  <= {cur[BITS-1], cur, {RATE_LOG2{1'b0}}};
        if (!empty) begin
          cur   <= mem[rd_ptr];
          delta <= {mem[rd_ptr][BITS-1], mem[rd_ptr]} - {cur[BITS-1], cur};
        end else begin
          delta    <= '0;
          underrun <= 1'b1;
        end
      end else begin
        acc <= acc + {{RATE_LOG2{delta[BITS]}}, delta};
      end

      // Slice is an arithmetic shift right by RATE_LOG2 (floor) truncated to BITS.
      out <= acc[BITS+RATE_LOG2-1:RATE_LOG2];
    end
  end

  // Each segment starts from exactly the previous target sample.
  a_segment_start : assert property (@(posedge clk) disable iff (!reset)
    (phase == '0) |-> (acc == {prev[BITS-1], prev, {RATE_LOG2{1'b0}}}));

endmodule

// File: tb/tb_fo_interp_upsampler.sv
// Bench for fo_interp_upsampler: directed scenarios plus random pushes, checked against
// a queue-based model that predicts each ramp value as prev + floor(delta*p / 2^R).
module tb_fo_interp_upsampler;
  localparam int BITS  = 16;
  localparam int R     = 2;
  localparam int R4    = 4;
  localparam int FL    = 2;
  localparam int DEPTH = 4;
  localparam int SEG   = 1 << R;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [BITS-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] out;
  logic            underrun;
  logic [FL:0]     fifo_level;

  logic [BITS-1:0] in_data4 = '0;
  logic            in_valid4 = 1'b0;
  logic            in_ready4;
  logic [BITS-1:0] out4;
  logic            underrun4;
  logic [FL:0]     fifo_level4;

  always #5 clk = ~clk;

  fo_interp_upsampler #(.BITS(BITS), .RATE_LOG2(R), .FIFO_LOG2(FL)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .underrun(underrun), .fifo_level(fifo_level)
  );

  fo_interp_upsampler #(.BITS(BITS), .RATE_LOG2(R4), .FIFO_LOG2(FL)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out(out4), .underrun(underrun4), .fifo_level(fifo_level4)
  );

  // Reference model state
  int              m_q[$];
  int              m_prev;
  int              m_cur;
  int              m_delta;
  bit              m_under;
  int              e;
  logic [BITS-1:0] out_hist[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge %0d: observed %0h expected %0h", tag, e, obs, exp);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    #1;
    check("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    check("in_ready4_in_reset", {31'b0, in_ready4}, 32'd0);
    @(posedge clk); #1;
    m_q.delete();
    m_prev = 0; m_cur = 0; m_delta = 0; m_under = 1'b0;
    e = 0;
    out_hist.delete();
    check("reset_out", {16'b0, out}, 32'd0);
    check("reset_underrun", {31'b0, underrun}, 32'd0);
    check("reset_level", {29'b0, fifo_level}, 32'd0);
    reset = 1'b1;
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
  endtask

  // One clock on the main DUT: offer (v, d), advance the model, compare outputs.
  task automatic cycle(input bit v, input int d);
    bit              acc;
    int              p;
    int              exp_out;
    logic [BITS-1:0] exp16;
    check("in_ready", {31'b0, in_ready}, {31'b0, (m_q.size() < DEPTH)});
    acc      = v && (m_q.size() < DEPTH);
    in_valid = v;
    in_data  = 16'(d);
    @(posedge clk); #1;
    e++;
    p       = (e - 1) % SEG;
    exp_out = m_prev + floor_div(m_delta * p, SEG);
    if (p == SEG - 1) begin
      if (m_q.size() > 0) begin
        m_prev  = m_cur;
        m_cur   = m_q.pop_front();
        m_delta = m_cur - m_prev;
      end else begin
        m_prev  = m_cur;
        m_delta = 0;
        m_under = 1'b1;
      end
    end
    if (acc) m_q.push_back(d);
    exp16 = 16'(exp_out);
    out_hist.push_back(out);
    check("out", {16'b0, out}, {16'b0, exp16});
    check("underrun", {31'b0, underrun}, {31'b0, m_under});
    check("fifo_level", {29'b0, fifo_level}, m_q.size());
    in_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int first, input int vals[4]);
    logic [BITS-1:0] v16;
    for (int i = 0; i < 4; i++) begin
      v16 = 16'(vals[i]);
      check(tag, {16'b0, out_hist[first-1+i]}, {16'b0, v16});
    end
  endtask

  initial begin
    logic signed [BITS-1:0] s;

    // Single sample, then hold with underrun
    do_reset();
    cycle(1, 400);
    repeat (11) cycle(0, 0);
    check_seq("t1_ramp", 5, '{0, 100, 200, 300});
    check_seq("t1_hold", 9, '{400, 400, 400, 400});

    // Reset mid-ramp
    do_reset();
    cycle(1, 400);
    repeat (6) cycle(0, 0);
    check("mid_ramp_out", {16'b0, out}, 32'd200);
    do_reset();

    // Up then down
    do_reset();
    cycle(1, 400);
    cycle(1, -400);
    repeat (14) cycle(0, 0);
    check_seq("t2_up", 5, '{0, 100, 200, 300});
    check_seq("t2_down", 9, '{400, 200, 0, -200});
    check_seq("t2_hold", 13, '{-400, -400, -400, -400});

    // Floor rounding
    do_reset();
    cycle(1, 0);
    cycle(1, 3);
    repeat (10) cycle(0, 0);
    check_seq("t3_floor", 9, '{0, 0, 1, 2});

    // Full-scale swing
    do_reset();
    cycle(1, 32767);
    cycle(1, -32768);
    repeat (10) cycle(0, 0);
    check_seq("t6_swing", 9, '{32767, 16383, -1, -16385});

    // FIFO fill on the RATE_LOG2=4 instance, starting right after its boundary at edge 16
    do_reset();
    repeat (16) cycle(0, 0);
    for (int i = 0; i < 5; i++) begin
      check("in_ready4", {31'b0, in_ready4}, (i < 4) ? 32'd1 : 32'd0);
      in_valid4 = 1'b1;
      in_data4  = 16'(100 * (i + 1));
      cycle(0, 0);
      in_valid4 = 1'b0;
      check("fifo_level4", {29'b0, fifo_level4}, (i < 4) ? (i + 1) : 4);
    end
    repeat (10) cycle(0, 0);
    check("fifo_level4_full", {29'b0, fifo_level4}, 32'd4);
    check("in_ready4_full", {31'b0, in_ready4}, 32'd0);
    cycle(0, 0);
    check("fifo_level4_pop", {29'b0, fifo_level4}, 32'd3);
    check("in_ready4_pop", {31'b0, in_ready4}, 32'd1);
    check("out4_hold", {16'b0, out4}, 32'd0);
    check("underrun4", {31'b0, underrun4}, 32'd1);

    // Random traffic: sparse then dense pushes
    do_reset();
    for (int i = 0; i < 200; i++) begin
      s = 16'($urandom);
      cycle($urandom_range(0, 5) == 0, s);
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      s = 16'($urandom);
      cycle($urandom_range(0, 1) == 0, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
